session_manager: RTL and testbench
==================================

// Module: session_manager
// PURPOSE
//  FIX session-layer controller for one TCP link. Consumes per-message verdicts from the parser/validator: validity, msg type and host.
//  Runs logon/active/resend/logout session FSM; emits 1-cycle action pulses (logon, heartbeat, resend, logout, disconnect) to the TX side.
//  Sits between the FIX header parser and the message builder/sequence-counter RAM.
// PARAMETERS
//  HOST_W    10   width of host index / seq-counter RAM address
//  COMPID_W  256  width of targetCompId_o
// PORTS
//  clk                    in   1         single clock, rising edge
//  rst                    in   1         reset, asynchronous, active-low
//  new_message_i          in   1         1-cycle strobe: verdict inputs valid this cycle
//  validity_i             in   3         0 VALID,1 SEQ_HIGH(gap),2 SEQ_LOW,3 GARBLED; 4-7 treated as GARBLED
//  timeout_i              in   1         peer heartbeat/logout timer expired (pulse)
//  connected_host_i       in   HOST_W    host index of current link
//  type_i                 in   3         0 HB,1 TEST_REQ,2 RESEND_REQ,3 REJECT,4 SEQ_RESET,5 LOGOUT,6 LOGON,7 APP
//  connected_i            in   1         TCP link up (level)
//  end_session_i          in   1         local request to log out (pulse)
//  resendDone_i           in   1         gap fill complete (pulse)
//  ignore_o, igonre_o     out  1 each    drop message; igonre_o is a legacy alias, always == ignore_o
//  disconnect_o           out  1         drop the link
//  error_type_o           out  3         last error: 0 NONE,1 GAP,2 SEQ_LOW,3 GARBLED,4 NO_LOGON,5 DUP_LOGON,6 TIMEOUT,7 rsvd
//  resendReq_o            out  1         send ResendRequest
//  targetCompId_o         out  COMPID_W  session peer id: zero-extended host index latched at logon
//  doResend_o             out  1         replay our messages (peer requested)
//  sendHeartbeat_o        out  1         send Heartbeat
//  sendLogout_o           out  1         send Logout
//  messagereceived_o      out  1         message accepted
//  updateSeqCounter_o     out  1         increment inbound seq counter
//  seqCounterLoc_o        out  HOST_W    counter RAM address (= host)
//  disconnect_host_num_o  out  HOST_W    host being dropped (held)
//  sendLogon_o            out  1         send Logon reply
//  end_session_o          out  1         session closed
// BEHAVIOUR
//  - Reset: every output 0, FSM IDLE. All outputs registered; response 1 cycle after the input strobe.
//  - Pulse outputs last exactly 1 cycle. Held outputs: error_type_o, targetCompId_o, seqCounterLoc_o, disconnect_host_num_o.
//  - Held outputs keep their value until the next update.
//  - Per-cycle priority: !connected_i > timeout_i > end_session_i > new_message_i. Lower-priority events that cycle are dropped silently.
//  - FSM states: IDLE, ACTIVE, RESEND, LOGOUT.
//  - Any non-IDLE state, !connected_i: end_session_o -> IDLE. IDLE ignores timeout_i, end_session_i and resendDone_i.
//  - IDLE, msg VALID+LOGON with connected_i=1: sendLogon_o, messagereceived_o, updateSeqCounter_o.
//    Latch seqCounterLoc_o/targetCompId_o from host; go ACTIVE.
//  - IDLE, any other msg: ignore_o, disconnect_o, error=NO_LOGON, disconnect_host_num_o=host. Stay IDLE.
//  - ACTIVE/RESEND, VALID msg: messagereceived_o, updateSeqCounter_o, seqCounterLoc_o=host, then by type:
//    TEST_REQ -> sendHeartbeat_o; RESEND_REQ -> doResend_o.
//    LOGOUT -> sendLogout_o, end_session_o, go IDLE.
//    LOGON -> disconnect_o, error=DUP_LOGON, go IDLE.
//    HB/REJECT/SEQ_RESET/APP -> no extra action.
//  - ACTIVE, SEQ_HIGH: ignore_o, resendReq_o, error=GAP, go RESEND.
//  - RESEND, SEQ_HIGH: ignore_o only; no duplicate resendReq_o.
//  - ACTIVE/RESEND, SEQ_LOW: sendLogout_o, disconnect_o, error=SEQ_LOW, disconnect_host_num_o=host, go IDLE.
//  - ACTIVE/RESEND, GARBLED: ignore_o, error=GARBLED; no seq update, no state change.
//  - RESEND, resendDone_i: go ACTIVE. A message in the same cycle is processed first; its transition wins if it leaves the session.
//  - ACTIVE/RESEND, timeout_i: sendLogout_o, disconnect_o, error=TIMEOUT, go IDLE.
//  - ACTIVE/RESEND, end_session_i: sendLogout_o, go LOGOUT.
//  - LOGOUT, VALID LOGOUT msg: messagereceived_o, updateSeqCounter_o, end_session_o, go IDLE.
//  - LOGOUT, timeout_i: disconnect_o, end_session_o, error=TIMEOUT, go IDLE.
//  - LOGOUT, any other message: ignore_o.
//  - A successful logon clears error_type_o to NONE.
// STRUCTURE
//  - Package session_pkg: validity, msg-type and error enums; FSM state typedef.
//  - Single module, no sub-modules. One state register plus an output register block.
// TESTING
//  1. Reset low mid-ACTIVE -> all outputs 0 immediately; state IDLE after release.
//  2. connected_i=1, VALID LOGON, host=5 -> next cycle sendLogon_o=1, updateSeqCounter_o=1.
//     seqCounterLoc_o=5, targetCompId_o=5, state ACTIVE.
//  3. ACTIVE, TEST_REQ valid -> sendHeartbeat_o 1 cycle. SEQ_HIGH -> resendReq_o, error_type_o=1.
//     Second SEQ_HIGH -> ignore_o only. resendDone_i -> ACTIVE.
//  4. IDLE, APP msg host=3 -> ignore_o=igonre_o=1, disconnect_o=1, error_type_o=4, disconnect_host_num_o=3.
//  5. ACTIVE, end_session_i -> sendLogout_o. Then VALID LOGOUT -> end_session_o, IDLE.
//     Repeat with timeout_i instead -> disconnect_o, error_type_o=6.
//  6. ACTIVE, timeout_i and new_message_i same cycle -> timeout handling only, no messagereceived_o.
//     connected_i drop -> end_session_o.

Source files
------------

// File: rtl/session_pkg.sv
// Shared types for the FIX session controller: verdict, message-type and
// error encodings plus the session FSM state.
package session_pkg;

    typedef enum logic [1:0] {
        VAL_VALID    = 2'd0,
        VAL_SEQ_HIGH = 2'd1,
        VAL_SEQ_LOW  = 2'd2,
        VAL_GARBLED  = 2'd3
    } validity_e;

    typedef enum logic [2:0] {
        MT_HB         = 3'd0,
        MT_TEST_REQ   = 3'd1,
        MT_RESEND_REQ = 3'd2,
        MT_REJECT     = 3'd3,
        MT_SEQ_RESET  = 3'd4,
        MT_LOGOUT     = 3'd5,
        MT_LOGON      = 3'd6,
        MT_APP        = 3'd7
    } msg_type_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_GAP       = 3'd1,
        ERR_SEQ_LOW   = 3'd2,
        ERR_GARBLED   = 3'd3,
        ERR_NO_LOGON  = 3'd4,
        ERR_DUP_LOGON = 3'd5,
        ERR_TIMEOUT   = 3'd6,
        ERR_RSVD      = 3'd7
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESEND = 2'd2,
        ST_LOGOUT = 2'd3
    } state_e;

    // Undefined verdict codes 4-7 are folded onto GARBLED.
    function automatic validity_e decode_validity(input logic [2:0] v);
        validity_e r;
        case (v)
            3'd0:    r = VAL_VALID;
            3'd1:    r = VAL_SEQ_HIGH;
            3'd2:    r = VAL_SEQ_LOW;
            default: r = VAL_GARBLED;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/session_manager.sv
// FIX session-layer controller for one TCP link: logon/active/resend/logout
// FSM producing registered one-cycle action pulses and held status outputs.
module session_manager
    import session_pkg::*;
#(
    parameter int HOST_W   = 10,
    parameter int COMPID_W = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_message_i,
    input  logic [2:0]          validity_i,
    input  logic                timeout_i,
    input  logic [HOST_W-1:0]   connected_host_i,
    input  logic [2:0]          type_i,
    input  logic                connected_i,
    input  logic                end_session_i,
    input  logic                resendDone_i,
    output logic                ignore_o,
    output logic                igonre_o,
    output logic                disconnect_o,
    output logic [2:0]          error_type_o,
    output logic                resendReq_o,
    output logic [COMPID_W-1:0] targetCompId_o,
    output logic                doResend_o,
    output logic                sendHeartbeat_o,
    output logic                sendLogout_o,
    output logic                messagereceived_o,
    output logic                updateSeqCounter_o,
    output logic [HOST_W-1:0]   seqCounterLoc_o,
    output logic [HOST_W-1:0]   disconnect_host_num_o,
    output logic                sendLogon_o,
    output logic                end_session_o
);

    state_e              state_r, state_s;
    validity_e           vld_s;
    msg_type_e           mt_s;
    logic                ignore_s, disconnect_s, resend_req_s, do_resend_s;
    logic                heartbeat_s, logout_s, msg_rx_s, upd_seq_s, logon_s, end_sess_s;
    logic [2:0]          err_s;
    logic [COMPID_W-1:0] tcid_s;
    logic [HOST_W-1:0]   loc_s, dhn_s;

    assign vld_s = decode_validity(validity_i);
    assign mt_s  = msg_type_e'(type_i);

    // Next-state and next-output decode, highest-priority event first.
    always_comb begin
        state_s      = state_r;
        ignore_s     = 1'b0;
        disconnect_s = 1'b0;
        resend_req_s = 1'b0;
        do_resend_s  = 1'b0;
        heartbeat_s  = 1'b0;
        logout_s     = 1'b0;
        msg_rx_s     = 1'b0;
        upd_seq_s    = 1'b0;
        logon_s      = 1'b0;
        end_sess_s   = 1'b0;
        err_s        = error_type_o;
        tcid_s       = targetCompId_o;
        loc_s        = seqCounterLoc_o;
        dhn_s        = disconnect_host_num_o;
        case (state_r)
            ST_IDLE: begin
                if (connected_i && new_message_i) begin
                    if (vld_s == VAL_VALID && mt_s == MT_LOGON) begin
                        logon_s   = 1'b1;
                        msg_rx_s  = 1'b1;
                        upd_seq_s = 1'b1;
                        loc_s     = connected_host_i;
                        tcid_s    = {{(COMPID_W-HOST_W){1'b0}}, connected_host_i};
                        err_s     = ERR_NONE;
                        state_s   = ST_ACTIVE;
                    end else begin
                        ignore_s     = 1'b1;
                        disconnect_s = 1'b1;
                        err_s        = ERR_NO_LOGON;
                        dhn_s        = connected_host_i;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE, ST_RESEND: begin
                if (!connected_i) begin
                    end_sess_s = 1'b1;
                    state_s    = ST_IDLE;
                end else if (timeout_i) begin
                    logout_s     = 1'b1;
                    disconnect_s = 1'b1;
                    err_s        = ERR_TIMEOUT;
                    state_s      = ST_IDLE;
                end else if (end_session_i) begin
                    logout_s = 1'b1;
                    state_s  = ST_LOGOUT;
                end else begin
                    if (new_message_i) begin
                        case (vld_s)
                            VAL_VALID: begin
                                msg_rx_s  = 1'b1;
                                upd_seq_s = 1'b1;
                                loc_s     = connected_host_i;
                                case (mt_s)
                                    MT_TEST_REQ:   heartbeat_s = 1'b1;
                                    MT_RESEND_REQ: do_resend_s = 1'b1;
                                    MT_LOGOUT: begin
                                        logout_s   = 1'b1;
                                        end_sess_s = 1'b1;
                                        state_s    = ST_IDLE;
                                    end
                                    MT_LOGON: begin
                                        disconnect_s = 1'b1;
                                        err_s        = ERR_DUP_LOGON;
                                        state_s      = ST_IDLE;
                                    end
                                    default: state_s = state_r;
                                endcase
                            end
                            VAL_SEQ_HIGH: begin
                                ignore_s = 1'b1;
                                if (state_r == ST_ACTIVE) begin
                                    resend_req_s = 1'b1;
                                    err_s        = ERR_GAP;
                                    state_s      = ST_RESEND;
                                end else begin
                                    state_s = state_r;
                                end
                            end
                            VAL_SEQ_LOW: begin
                                logout_s     = 1'b1;
                                disconnect_s = 1'b1;
                                err_s        = ERR_SEQ_LOW;
                                dhn_s        = connected_host_i;
                                state_s      = ST_IDLE;
                            end
                            default: begin
                                ignore_s = 1'b1;
                                err_s    = ERR_GARBLED;
                            end
                        endcase
                    end else begin
                        state_s = state_r;
                    end
                    // Gap fill completes unless the same-cycle message closed the session.
                    if (state_r == ST_RESEND && resendDone_i && state_s != ST_IDLE) begin
                        state_s = ST_ACTIVE;
                    end else begin
                        state_s = state_s;
                    end
                end
            end
            ST_LOGOUT: begin
                if (!connected_i) begin
                    end_sess_s = 1'b1;
                    state_s    = ST_IDLE;
                end else if (timeout_i) begin
                    disconnect_s = 1'b1;
                    end_sess_s   = 1'b1;
                    err_s        = ERR_TIMEOUT;
                    state_s      = ST_IDLE;
                end else if (new_message_i) begin
                    if (vld_s == VAL_VALID && mt_s == MT_LOGOUT) begin
                        msg_rx_s   = 1'b1;
                        upd_seq_s  = 1'b1;
                        end_sess_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        ignore_s = 1'b1;
                    end
                end else begin
                    state_s = ST_LOGOUT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r               <= ST_IDLE;
            ignore_o              <= 1'b0;
            igonre_o              <= 1'b0;
            disconnect_o          <= 1'b0;
            error_type_o          <= 3'd0;
            resendReq_o           <= 1'b0;
            targetCompId_o        <= {COMPID_W{1'b0}};
            doResend_o            <= 1'b0;
            sendHeartbeat_o       <= 1'b0;
            sendLogout_o          <= 1'b0;
            messagereceived_o     <= 1'b0;
            updateSeqCounter_o    <= 1'b0;
            seqCounterLoc_o       <= {HOST_W{1'b0}};
            disconnect_host_num_o <= {HOST_W{1'b0}};
            sendLogon_o           <= 1'b0;
            end_session_o         <= 1'b0;
        end else begin
            state_r               <= state_s;
            ignore_o              <= ignore_s;
            igonre_o              <= ignore_s;
            disconnect_o          <= disconnect_s;
            error_type_o          <= err_s;
            resendReq_o           <= resend_req_s;
            targetCompId_o        <= tcid_s;
            doResend_o            <= do_resend_s;
            sendHeartbeat_o       <= heartbeat_s;
            sendLogout_o          <= logout_s;
            messagereceived_o     <= msg_rx_s;
            updateSeqCounter_o    <= upd_seq_s;
            seqCounterLoc_o       <= loc_s;
            disconnect_host_num_o <= dhn_s;
            sendLogon_o           <= logon_s;
            end_session_o         <= end_sess_s;
        end
    end

endmodule

// File: tb/tb_session_manager.sv
// Scoreboard bench for session_manager: directed steps push the hand-computed
// next-cycle output image; a monitor pops and compares after each rising edge.
module tb_session_manager;

    localparam int HOST_W   = 10;
    localparam int COMPID_W = 256;
    localparam int OBS_W    = 11 + 3 + COMPID_W + 2*HOST_W;

    // Pulse mask bit order: ignore, disconnect, resendReq, doResend, heartbeat,
    // logout, msgrx, updseq, logon, end_session.
    localparam logic [9:0] P_IGN = 10'b10_0000_0000;
    localparam logic [9:0] P_DIS = 10'b01_0000_0000;
    localparam logic [9:0] P_RRQ = 10'b00_1000_0000;
    localparam logic [9:0] P_DRS = 10'b00_0100_0000;
    localparam logic [9:0] P_HB  = 10'b00_0010_0000;
    localparam logic [9:0] P_LGO = 10'b00_0001_0000;
    localparam logic [9:0] P_MSG = 10'b00_0000_1000;
    localparam logic [9:0] P_UPD = 10'b00_0000_0100;
    localparam logic [9:0] P_LGN = 10'b00_0000_0010;
    localparam logic [9:0] P_END = 10'b00_0000_0001;
    localparam logic [9:0] P_NONE = 10'b00_0000_0000;

    localparam logic [2:0] V_OK = 3'd0, V_HI = 3'd1, V_LO = 3'd2;
    localparam logic [2:0] T_HB = 3'd0, T_TR = 3'd1, T_RR = 3'd2, T_LGO = 3'd5, T_LGN = 3'd6, T_APP = 3'd7;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                new_message = 1'b0;
    logic [2:0]          validity = 3'd0;
    logic                timeout = 1'b0;
    logic [HOST_W-1:0]   host = '0;
    logic [2:0]          mtype = 3'd0;
    logic                connected = 1'b0;
    logic                end_session = 1'b0;
    logic                resend_done = 1'b0;

    logic                ignore, igonre, disconnect, resend_req, do_resend, send_hb;
    logic                send_logout, msg_rx, upd_seq, send_logon, end_sess;
    logic [2:0]          err;
    logic [COMPID_W-1:0] tcid;
    logic [HOST_W-1:0]   loc, dhn;

    session_manager #(.HOST_W(HOST_W), .COMPID_W(COMPID_W)) dut (
        .clk(clk), .rst(rst),
        .new_message_i(new_message), .validity_i(validity), .timeout_i(timeout),
        .connected_host_i(host), .type_i(mtype), .connected_i(connected),
        .end_session_i(end_session), .resendDone_i(resend_done),
        .ignore_o(ignore), .igonre_o(igonre), .disconnect_o(disconnect),
        .error_type_o(err), .resendReq_o(resend_req), .targetCompId_o(tcid),
        .doResend_o(do_resend), .sendHeartbeat_o(send_hb), .sendLogout_o(send_logout),
        .messagereceived_o(msg_rx), .updateSeqCounter_o(upd_seq), .seqCounterLoc_o(loc),
        .disconnect_host_num_o(dhn), .sendLogon_o(send_logon), .end_session_o(end_sess)
    );

    always #5 clk = ~clk;

    logic [OBS_W-1:0] obs;
    assign obs = {ignore, igonre, disconnect, resend_req, do_resend, send_hb, send_logout,
                  msg_rx, upd_seq, send_logon, end_sess, err, tcid, loc, dhn};

    typedef struct {
        string            name;
        logic [OBS_W-1:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input string name, input logic [OBS_W-1:0] act,
                                  input logic [OBS_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: compare every registered response against the scoreboard head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, obs, e.v);
        end
    end

    task automatic step(input string name, input logic conn, input logic nm,
                        input logic [2:0] vld, input logic [2:0] typ, input logic [HOST_W-1:0] h,
                        input logic tmo, input logic es, input logic rd,
                        input logic [9:0] p, input logic [2:0] e_err,
                        input logic [HOST_W-1:0] e_tcid, input logic [HOST_W-1:0] e_loc,
                        input logic [HOST_W-1:0] e_dhn);
        exp_t e;
        @(negedge clk);
        connected   = conn;
        new_message = nm;
        validity    = vld;
        mtype       = typ;
        host        = h;
        timeout     = tmo;
        end_session = es;
        resend_done = rd;
        e.name = name;
        e.v    = {p[9], p[9], p[8:0], e_err, {(COMPID_W-HOST_W){1'b0}}, e_tcid, e_loc, e_dhn};
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", obs, '0);
        rst = 1'b1;

        //    name           conn nm  vld   typ    host tmo es rd  pulses                      err  tcid loc dhn
        step("idle_app",     1'b1,1'b1,V_OK,T_APP, 10'd3,1'b0,1'b0,1'b0, P_IGN|P_DIS,          3'd4,10'd0,10'd0,10'd3);
        step("logon5",       1'b1,1'b1,V_OK,T_LGN, 10'd5,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd5,10'd5,10'd3);
        step("quiet",        1'b1,1'b0,V_OK,T_HB,  10'd5,1'b0,1'b0,1'b0, P_NONE,               3'd0,10'd5,10'd5,10'd3);
        step("test_req",     1'b1,1'b1,V_OK,T_TR,  10'd5,1'b0,1'b0,1'b0, P_MSG|P_UPD|P_HB,     3'd0,10'd5,10'd5,10'd3);
        step("seq_high",     1'b1,1'b1,V_HI,T_APP, 10'd5,1'b0,1'b0,1'b0, P_IGN|P_RRQ,          3'd1,10'd5,10'd5,10'd3);
        step("seq_high_2",   1'b1,1'b1,V_HI,T_APP, 10'd5,1'b0,1'b0,1'b0, P_IGN,                3'd1,10'd5,10'd5,10'd3);
        step("garbled_6",    1'b1,1'b1,3'd6,T_APP, 10'd5,1'b0,1'b0,1'b0, P_IGN,                3'd3,10'd5,10'd5,10'd3);
        step("resend_done",  1'b1,1'b0,V_OK,T_HB,  10'd5,1'b0,1'b0,1'b1, P_NONE,               3'd3,10'd5,10'd5,10'd3);
        step("seq_high_act", 1'b1,1'b1,V_HI,T_APP, 10'd5,1'b0,1'b0,1'b0, P_IGN|P_RRQ,          3'd1,10'd5,10'd5,10'd3);
        step("done_with_hb", 1'b1,1'b1,V_OK,T_HB,  10'd5,1'b0,1'b0,1'b1, P_MSG|P_UPD,          3'd1,10'd5,10'd5,10'd3);
        step("resend_req",   1'b1,1'b1,V_OK,T_RR,  10'd5,1'b0,1'b0,1'b0, P_MSG|P_UPD|P_DRS,    3'd1,10'd5,10'd5,10'd3);
        step("end_session",  1'b1,1'b0,V_OK,T_HB,  10'd5,1'b0,1'b1,1'b0, P_LGO,                3'd1,10'd5,10'd5,10'd3);
        step("logout_app",   1'b1,1'b1,V_OK,T_APP, 10'd5,1'b0,1'b0,1'b0, P_IGN,                3'd1,10'd5,10'd5,10'd3);
        step("logout_ack",   1'b1,1'b1,V_OK,T_LGO, 10'd5,1'b0,1'b0,1'b0, P_MSG|P_UPD|P_END,    3'd1,10'd5,10'd5,10'd3);
        step("logon7",       1'b1,1'b1,V_OK,T_LGN, 10'd7,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd7,10'd7,10'd3);
        step("end_session2", 1'b1,1'b0,V_OK,T_HB,  10'd7,1'b0,1'b1,1'b0, P_LGO,                3'd0,10'd7,10'd7,10'd3);
        step("logout_tmo",   1'b1,1'b0,V_OK,T_HB,  10'd7,1'b1,1'b0,1'b0, P_DIS|P_END,          3'd6,10'd7,10'd7,10'd3);
        step("logon2",       1'b1,1'b1,V_OK,T_LGN, 10'd2,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd2,10'd2,10'd3);
        step("tmo_and_msg",  1'b1,1'b1,V_OK,T_TR,  10'd2,1'b1,1'b0,1'b0, P_LGO|P_DIS,          3'd6,10'd2,10'd2,10'd3);
        step("logon4",       1'b1,1'b1,V_OK,T_LGN, 10'd4,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd4,10'd4,10'd3);
        step("link_drop",    1'b0,1'b1,V_OK,T_APP, 10'd4,1'b0,1'b0,1'b0, P_END,                3'd0,10'd4,10'd4,10'd3);
        step("idle_app9",    1'b1,1'b1,V_OK,T_APP, 10'd9,1'b0,1'b0,1'b0, P_IGN|P_DIS,          3'd4,10'd4,10'd4,10'd9);
        step("logon6",       1'b1,1'b1,V_OK,T_LGN, 10'd6,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd6,10'd6,10'd9);
        step("seq_low",      1'b1,1'b1,V_LO,T_APP, 10'd6,1'b0,1'b0,1'b0, P_LGO|P_DIS,          3'd2,10'd6,10'd6,10'd6);
        step("logon1",       1'b1,1'b1,V_OK,T_LGN, 10'd1,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd1,10'd1,10'd6);
        step("dup_logon",    1'b1,1'b1,V_OK,T_LGN, 10'd1,1'b0,1'b0,1'b0, P_MSG|P_UPD|P_DIS,    3'd5,10'd1,10'd1,10'd6);
        step("logon8",       1'b1,1'b1,V_OK,T_LGN, 10'd8,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd8,10'd8,10'd6);
        step("active_lgo",   1'b1,1'b1,V_OK,T_LGO, 10'd8,1'b0,1'b0,1'b0, P_MSG|P_UPD|P_LGO|P_END, 3'd0,10'd8,10'd8,10'd6);
        step("logon5b",      1'b1,1'b1,V_OK,T_LGN, 10'd5,1'b0,1'b0,1'b0, P_LGN|P_MSG|P_UPD,    3'd0,10'd5,10'd5,10'd6);
        step("quiet2",       1'b1,1'b0,V_OK,T_HB,  10'd5,1'b0,1'b0,1'b0, P_NONE,               3'd0,10'd5,10'd5,10'd6);
        drain();

        // Asynchronous reset in the middle of an active session.
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset", obs, '0);
        @(negedge clk);
        rst = 1'b1;
        step("post_reset",   1'b1,1'b1,V_OK,T_APP, 10'd3,1'b0,1'b0,1'b0, P_IGN|P_DIS,          3'd4,10'd0,10'd0,10'd3);
        step("idle_tail",    1'b1,1'b0,V_OK,T_HB,  10'd3,1'b0,1'b0,1'b0, P_NONE,               3'd4,10'd0,10'd0,10'd3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
